// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: receive-side checker for the one-hot traffic-light bus.
// It locks onto the G->Y->R->G sequence, enforces per-phase dwell bounds and latches the first violation.
// All outputs are registered, with one clock of latency. It never back-pressures the controller.
// Ports:
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   light[0:2]       : bit0 RED, bit1 GREEN, bit2 YELLOW (RED=3'b100, GREEN=3'b010, YELLOW=3'b001)
//   clear_fault      : synchronous pulse that releases a latched fault and restarts acquisition
//   phase            : 0 none, 1 GREEN, 2 YELLOW, 3 RED
//   sync, fault      : locked flag, sticky violation flag
//   fault_code       : 0 none, 1 not one-hot, 2 illegal successor, 3 overstay, 4 understay
//   round_count      : completed RED->GREEN rounds while locked (saturating)
//   dwell_count      : consecutive samples of the current value (saturating)
module traffic_light_monitor #(
  parameter int MIN_GREEN  = 1,
  parameter int MAX_GREEN  = 1,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_YELLOW = 1,
  parameter int MIN_RED    = 1,
  parameter int MAX_RED    = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [0:2]       light,
  input  logic             clear_fault,
  output logic [1:0]       phase,
  output logic             sync,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [15:0]      round_count,
  output logic [CNT_W-1:0] dwell_count
);

  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  localparam logic [0:2] L_RED    = 3'b100;
  localparam logic [0:2] L_GREEN  = 3'b010;
  localparam logic [0:2] L_YELLOW = 3'b001;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       r_state, w_state_n;
  logic [0:2]       r_prev,  w_prev_n;
  logic [1:0]       r_phase, w_phase_n;
  logic             r_sync,  w_sync_n;
  logic             r_fault, w_fault_n;
  logic [2:0]       r_code,  w_code_n;
  logic [15:0]      r_round, w_round_n;
  logic [CNT_W-1:0] r_dwell, w_dwell_n;

  logic             w_valid, w_same, w_legal;
  logic [1:0]       w_dec;
  logic [CNT_W-1:0] w_min, w_max, w_dwell_inc;

  always_comb begin
    w_dec = 2'd0;
    case (light)
      L_GREEN:  w_dec = 2'd1;
      L_YELLOW: w_dec = 2'd2;
      L_RED:    w_dec = 2'd3;
      default:  w_dec = 2'd0;
    endcase
  end

  assign w_valid = (w_dec != 2'd0);
  assign w_same  = (light == r_prev);
  // Only exact one-hot patterns match, so an invalid previous sample never forms a legal pair.
  assign w_legal = ((r_prev == L_GREEN)  && (light == L_YELLOW)) ||
                   ((r_prev == L_YELLOW) && (light == L_RED))    ||
                   ((r_prev == L_RED)    && (light == L_GREEN));
  assign w_dwell_inc = (r_dwell == CNT_MAX) ? r_dwell : r_dwell + CNT_ONE;

  // While locked, r_phase always tracks the previous sample, so it selects the bounds of the phase being held or left.
  always_comb begin
    w_min = CNT_W'(MIN_GREEN);
    w_max = CNT_W'(MAX_GREEN);
    case (r_phase)
      2'd2: begin
        w_min = CNT_W'(MIN_YELLOW);
        w_max = CNT_W'(MAX_YELLOW);
      end
      2'd3: begin
        w_min = CNT_W'(MIN_RED);
        w_max = CNT_W'(MAX_RED);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_prev_n  = r_prev;
    w_phase_n = r_phase;
    w_sync_n  = r_sync;
    w_fault_n = r_fault;
    w_code_n  = r_code;
    w_round_n = r_round;
    w_dwell_n = r_dwell;
    case (r_state)
      ST_UNSYNC: begin
        w_prev_n  = light;
        w_phase_n = w_dec;
        if (!w_valid) begin
          w_dwell_n = '0;
        end else if (w_same) begin
          w_dwell_n = w_dwell_inc;
        end else begin
          w_dwell_n = CNT_ONE;
          if (w_legal) begin
            w_state_n = ST_SYNC;
            w_sync_n  = 1'b1;
          end
        end
      end
      ST_SYNC: begin
        w_prev_n = light;
        // On a violation, phase and dwell keep their pre-violation values.
        if (w_same) begin
          if (r_dwell == w_max) begin
            w_code_n = 3'd3;
          end else begin
            w_dwell_n = w_dwell_inc;
          end
        end else if (!w_valid) begin
          w_code_n = 3'd1;
        end else if (!w_legal) begin
          w_code_n = 3'd2;
        end else if (r_dwell < w_min) begin
          w_code_n = 3'd4;
        end else begin
          w_dwell_n = CNT_ONE;
          w_phase_n = w_dec;
          if ((r_prev == L_RED) && (r_round != 16'hFFFF)) begin
            w_round_n = r_round + 16'd1;
          end
        end
        if (w_code_n != 3'd0) begin
          w_state_n = ST_FAULT;
          w_fault_n = 1'b1;
          w_sync_n  = 1'b0;
          w_prev_n  = r_prev;
        end
      end
      default: begin
        if (clear_fault) begin
          w_state_n = ST_UNSYNC;
          w_prev_n  = light;
          w_phase_n = 2'd0;
          w_fault_n = 1'b0;
          w_code_n  = 3'd0;
          w_dwell_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_UNSYNC;
      r_prev  <= 3'b000;
      r_phase <= 2'd0;
      r_sync  <= 1'b0;
      r_fault <= 1'b0;
      r_code  <= 3'd0;
      r_round <= 16'd0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_n;
      r_prev  <= w_prev_n;
      r_phase <= w_phase_n;
      r_sync  <= w_sync_n;
      r_fault <= w_fault_n;
      r_code  <= w_code_n;
      r_round <= w_round_n;
      r_dwell <= w_dwell_n;
    end
  end

  assign phase       = r_phase;
  assign sync        = r_sync;
  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign round_count = r_round;
  assign dwell_count = r_dwell;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam logic [0:2] R = 3'b100;
  localparam logic [0:2] G = 3'b010;
  localparam logic [0:2] Y = 3'b001;

  logic       clock = 1'b0;
  logic       reset;
  logic [0:2] light;
  logic       clear_fault;

  // u0: default bounds, u1: MAX_GREEN = 2, u2: MIN_RED = 3
  logic [1:0]  ph0, ph1, ph2;
  logic        sy0, sy1, sy2;
  logic        fl0, fl1, fl2;
  logic [2:0]  fc0, fc1, fc2;
  logic [15:0] rc0, rc1, rc2;
  logic [7:0]  dc0, dc1, dc2;

  int n_checks = 0;
  int n_errors = 0;

  traffic_light_monitor u0 (
    .clock(clock), .reset(reset), .light(light), .clear_fault(clear_fault),
    .phase(ph0), .sync(sy0), .fault(fl0), .fault_code(fc0),
    .round_count(rc0), .dwell_count(dc0)
  );

  traffic_light_monitor #(.MAX_GREEN(2)) u1 (
    .clock(clock), .reset(reset), .light(light), .clear_fault(clear_fault),
    .phase(ph1), .sync(sy1), .fault(fl1), .fault_code(fc1),
    .round_count(rc1), .dwell_count(dc1)
  );

  traffic_light_monitor #(.MIN_RED(3), .MAX_RED(4)) u2 (
    .clock(clock), .reset(reset), .light(light), .clear_fault(clear_fault),
    .phase(ph2), .sync(sy2), .fault(fl2), .fault_code(fc2),
    .round_count(rc2), .dwell_count(dc2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a sample, let one rising edge take it, then settle 1ns past the edge.
  task automatic drive(input logic [0:2] v);
    light = v;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [0:2] seq [3];

  initial begin
    seq[0] = R; seq[1] = G; seq[2] = Y;
    reset = 1'b1;
    light = 3'b000;
    clear_fault = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_phase", 32'(ph0), 32'd0);
    chk("rst_sync",  32'(sy0), 32'd0);
    chk("rst_fault", 32'(fl0), 32'd0);
    chk("rst_code",  32'(fc0), 32'd0);
    chk("rst_round", 32'(rc0), 32'd0);
    chk("rst_dwell", 32'(dc0), 32'd0);
    reset = 1'b0;

    // R,G,Y,... for 31 samples: lock on the 2nd; G samples 5,8,...,29 each complete a round.
    for (int k = 1; k <= 31; k++) begin
      drive(seq[(k-1)%3]);
      if (k == 1) begin
        chk("acq_sync_k1", 32'(sy0), 32'd0);
        chk("acq_dwell_k1", 32'(dc0), 32'd1);
      end else begin
        chk("run_sync", 32'(sy0), 32'd1);
        chk("run_dwell", 32'(dc0), 32'd1);
        chk("run_fault", 32'(fl0), 32'd0);
      end
    end
    chk("run_round31", 32'(rc0), 32'd9);
    chk("run_phase31", 32'(ph0), 32'd3);
    drive(G);
    chk("run_round32", 32'(rc0), 32'd10);

    // Illegal successor G->R; later activity is ignored.
    drive(R);
    chk("illeg_fault", 32'(fl0), 32'd1);
    chk("illeg_code",  32'(fc0), 32'd2);
    chk("illeg_phase", 32'(ph0), 32'd1);
    chk("illeg_sync",  32'(sy0), 32'd0);
    drive(Y);
    drive(3'b111);
    drive(G);
    chk("frz_code",  32'(fc0), 32'd2);
    chk("frz_phase", 32'(ph0), 32'd1);
    chk("frz_dwell", 32'(dc0), 32'd1);
    chk("frz_round", 32'(rc0), 32'd10);

    // Clear, then re-acquire; the G on the clear edge becomes the previous sample.
    clear_fault = 1'b1;
    drive(G);
    clear_fault = 1'b0;
    chk("clr_fault", 32'(fl0), 32'd0);
    chk("clr_code",  32'(fc0), 32'd0);
    chk("clr_phase", 32'(ph0), 32'd0);
    chk("clr_dwell", 32'(dc0), 32'd0);
    chk("clr_round", 32'(rc0), 32'd10);
    drive(Y);
    chk("reacq_sync",  32'(sy0), 32'd1);
    chk("reacq_phase", 32'(ph0), 32'd2);
    drive(R);
    drive(G);
    chk("reacq_round", 32'(rc0), 32'd11);

    // Not one-hot while locked.
    drive(3'b110);
    chk("nonehot_code",  32'(fc0), 32'd1);
    chk("nonehot_phase", 32'(ph0), 32'd1);

    // Asynchronous reset mid-cycle, checked before the next rising edge.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_round", 32'(rc0), 32'd0);
    chk("arst_fault", 32'(fl0), 32'd0);
    chk("arst_code",  32'(fc0), 32'd0);
    chk("arst_phase", 32'(ph0), 32'd0);
    chk("arst_sync",  32'(sy0), 32'd0);
    chk("arst_dwell", 32'(dc0), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Invalid samples in acquisition are ignored without a fault.
    drive(3'b000);
    chk("uns_zero_phase", 32'(ph0), 32'd0);
    chk("uns_zero_fault", 32'(fl0), 32'd0);
    drive(R);
    drive(R);
    chk("uns_rr_dwell", 32'(dc0), 32'd2);
    chk("uns_rr_phase", 32'(ph0), 32'd3);
    drive(3'b000);
    chk("uns_z2_dwell", 32'(dc0), 32'd0);
    chk("uns_z2_fault", 32'(fl0), 32'd0);

    // Overstay with MAX_GREEN = 2.
    do_reset();
    drive(Y);
    drive(R);
    drive(G);
    drive(G);
    chk("ovr_g2_fault", 32'(fl1), 32'd0);
    chk("ovr_g2_dwell", 32'(dc1), 32'd2);
    drive(G);
    chk("ovr_code",  32'(fc1), 32'd3);
    chk("ovr_dwell", 32'(dc1), 32'd2);
    chk("ovr_phase", 32'(ph1), 32'd1);

    // Understay with MIN_RED = 3.
    do_reset();
    drive(G);
    drive(Y);
    drive(R);
    drive(R);
    drive(G);
    chk("und_code",  32'(fc2), 32'd4);
    chk("und_phase", 32'(ph2), 32'd3);
    chk("und_dwell", 32'(dc2), 32'd2);

    do_reset();
    drive(G);
    drive(Y);
    drive(R);
    drive(R);
    drive(R);
    drive(G);
    chk("minok_round", 32'(rc2), 32'd1);
    chk("minok_fault", 32'(fl2), 32'd0);
    chk("minok_phase", 32'(ph2), 32'd1);
    chk("minok_dwell", 32'(dc2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
